mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side (fetch, data) and memory-side buses of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding requesters and memory.
interface mem_arbiter_if;
  logic        if_read;
  logic [15:0] if_address;
  logic [15:0] if_rdata;
  logic        if_resp;

  logic        d_read;
  logic        d_write;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] d_rdata;
  logic        d_resp;

  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  if_read, if_address,
    output if_rdata, if_resp,
    input  d_read, d_write, d_address, d_wdata, d_wmask,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output if_read, if_address,
    input  if_rdata, if_resp,
    output d_read, d_write, d_address, d_wdata, d_wmask,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data memory arbiter: strobe one cycle after grant, held until pmem_resp; resp is combinational on pmem_resp.
// Fixed data-over-fetch priority; define MEM_ARBITER_RR_EN for alternating priority on contention.
module mem_arbiter (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t      state_q;
  logic        cmd_read_q;
  logic        cmd_write_q;
  logic [15:0] cmd_addr_q;
  logic [15:0] cmd_wdata_q;
  logic [1:0]  cmd_wmask_q;

  logic d_req;
  logic i_req;
  logic pick_d;

  assign d_req = bus.d_read | bus.d_write;
  assign i_req = bus.if_read;

`ifdef MEM_ARBITER_RR_EN
  // last_grant_q: 1 = data side was granted last, 0 = fetch side
  logic last_grant_q;
  assign pick_d = d_req & (~i_req | ~last_grant_q);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q     <= GRANT_D;
            // simultaneous read+write is issued as a write
            cmd_write_q <= bus.d_write;
            cmd_read_q  <= bus.d_read & ~bus.d_write;
            cmd_addr_q  <= bus.d_address;
            cmd_wdata_q <= bus.d_wdata;
            cmd_wmask_q <= bus.d_wmask;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= 1'b1;
`endif
          end else if (i_req) begin
            state_q     <= GRANT_I;
            cmd_write_q <= 1'b0;
            cmd_read_q  <= 1'b1;
            cmd_addr_q  <= bus.if_address;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= 2'b11;
`ifdef MEM_ARBITER_RR_EN
            last_grant_q <= 1'b0;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.pmem_resp) begin
            state_q     <= IDLE;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_read_q  <= 1'b0;
          cmd_write_q <= 1'b0;
          cmd_addr_q  <= '0;
          cmd_wdata_q <= '0;
          cmd_wmask_q <= '0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = cmd_read_q;
  assign bus.pmem_write   = cmd_write_q;
  assign bus.pmem_address = cmd_addr_q;
  assign bus.pmem_wdata   = cmd_wdata_q;
  assign bus.pmem_wmask   = cmd_wmask_q;

  // Responses are steered by the current grant, so pmem_resp in IDLE reaches nobody.
  assign bus.if_resp  = (state_q == GRANT_I) & bus.pmem_resp;
  assign bus.if_rdata = (state_q == GRANT_I) ? bus.pmem_rdata : 16'h0000;
  assign bus.d_resp   = (state_q == GRANT_D) & bus.pmem_resp;
  assign bus.d_rdata  = (state_q == GRANT_D) ? bus.pmem_rdata : 16'h0000;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs change and outputs are sampled around the falling edge.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic busy;
  int   errors;
  int   checks;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs();
    bus.if_read    = 1'b0;
    bus.if_address = 16'h0000;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = 16'h0000;
    bus.d_wdata    = 16'h0000;
    bus.d_wmask    = 2'b00;
    bus.pmem_rdata = 16'h0000;
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({busy, bus.pmem_read, bus.pmem_write, bus.if_resp, bus.d_resp} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, bus.pmem_read, bus.pmem_write, bus.if_resp, bus.d_resp});
    end
    checks++;
    if ({bus.pmem_address, bus.pmem_wdata, bus.pmem_wmask} !== 34'h0) begin
      errors++;
      $display("FAIL reset_cmd: got %h want 0", {bus.pmem_address, bus.pmem_wdata, bus.pmem_wmask});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.if_read    = 1'b1;
    bus.if_address = 16'h0040;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0: busy=%b pmem_read=%b want 0 0", busy, bus.pmem_read);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1234;
        bus.if_read    = 1'b0;
      end
      #1;
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 16'h0040) begin
        errors++;
        $display("FAIL fetch_strobe c%0d: rd=%b wr=%b addr=%h want 1 0 0040", c, bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      if (c == 1) begin
        checks++;
        if (bus.pmem_wmask !== 2'b11 || bus.pmem_wdata !== 16'h0000) begin
          errors++;
          $display("FAIL fetch_wmask: wmask=%b wdata=%h want 11 0000", bus.pmem_wmask, bus.pmem_wdata);
        end
      end
      if (c < 4) begin
        checks++;
        if (bus.if_resp !== 1'b0) begin
          errors++;
          $display("FAIL fetch_early_resp c%0d: got %b want 0", c, bus.if_resp);
        end
      end else begin
        checks++;
        if (bus.if_resp !== 1'b1 || bus.if_rdata !== 16'h1234) begin
          errors++;
          $display("FAIL fetch_resp: resp=%b rdata=%h want 1 1234", bus.if_resp, bus.if_rdata);
        end
        checks++;
        if (bus.d_resp !== 1'b0 || bus.d_rdata !== 16'h0000) begin
          errors++;
          $display("FAIL fetch_d_quiet: d_resp=%b d_rdata=%h want 0 0000", bus.d_resp, bus.d_rdata);
        end
      end
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c5: busy=%b pmem_read=%b want 0 0", busy, bus.pmem_read);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'hDEAD;
    #1;
    checks++;
    if ({bus.if_resp, bus.d_resp, busy} !== 3'b000 || bus.if_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL spurious_resp: if_resp,d_resp,busy=%b if_rdata=%h want 000 0000", {bus.if_resp, bus.d_resp, busy}, bus.if_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL spurious_state: busy=%b rd=%b wr=%b want 0 0 0", busy, bus.pmem_read, bus.pmem_write);
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.d_write   = 1'b1;
    bus.d_address = 16'h2001;
    bus.d_wdata   = 16'hAB00;
    bus.d_wmask   = 2'b10;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.pmem_resp = 1'b1;
        bus.d_write   = 1'b0;
      end
      #1;
      checks++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 16'h2001 ||
          bus.pmem_wmask !== 2'b10 || bus.pmem_wdata !== 16'hAB00) begin
        errors++;
        $display("FAIL store_cmd c%0d: wr=%b rd=%b addr=%h wmask=%b wdata=%h want 1 0 2001 10 ab00",
                 c, bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wmask, bus.pmem_wdata);
      end
      checks++;
      if (bus.d_resp !== (c == 2) || bus.if_resp !== 1'b0) begin
        errors++;
        $display("FAIL store_resp c%0d: d_resp=%b if_resp=%b want %b 0", c, bus.d_resp, bus.if_resp, (c == 2));
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if (bus.d_resp !== 1'b0 || busy !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL store_end: d_resp=%b busy=%b wr=%b want 0 0 0", bus.d_resp, busy, bus.pmem_write);
    end
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 16'h00A0;
    bus.d_wdata   = 16'h5A5A;
    bus.d_wmask   = 2'b11;
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    #1;
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.d_resp !== 1'b1) begin
      errors++;
      $display("FAIL rw_both: wr=%b rd=%b d_resp=%b want 1 0 1", bus.pmem_write, bus.pmem_read, bus.d_resp);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rw_both_end: busy=%b want 0", busy);
    end
  endtask

  // Runs right after a data-side grant, so the alternating build serves fetch first.
  task automatic test_contention();
    logic        first_d;
    logic [15:0] a_first;
    logic [15:0] a_second;
`ifdef MEM_ARBITER_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    a_first  = first_d ? 16'h0200 : 16'h0100;
    a_second = first_d ? 16'h0100 : 16'h0200;
    @(negedge clk);
    bus.if_read    = 1'b1;
    bus.if_address = 16'h0100;
    bus.d_read     = 1'b1;
    bus.d_address  = 16'h0200;
    @(negedge clk);
    #1;
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== a_first) begin
      errors++;
      $display("FAIL cont_first_addr: rd=%b addr=%h want 1 %h", bus.pmem_read, bus.pmem_address, a_first);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'hBEEF;
    if (first_d) bus.d_read = 1'b0;
    else         bus.if_read = 1'b0;
    #1;
    checks++;
    if (bus.d_resp !== first_d || bus.if_resp !== ~first_d) begin
      errors++;
      $display("FAIL cont_first_resp: d_resp=%b if_resp=%b want %b %b", bus.d_resp, bus.if_resp, first_d, ~first_d);
    end
    checks++;
    if (bus.d_rdata !== (first_d ? 16'hBEEF : 16'h0000) || bus.if_rdata !== (first_d ? 16'h0000 : 16'hBEEF)) begin
      errors++;
      $display("FAIL cont_first_rdata: d_rdata=%h if_rdata=%h", bus.d_rdata, bus.if_rdata);
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL cont_gap: busy=%b rd=%b want 0 0", busy, bus.pmem_read);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || bus.pmem_read !== 1'b1 || bus.pmem_address !== a_second) begin
      errors++;
      $display("FAIL cont_second_addr: busy=%b rd=%b addr=%h want 1 1 %h", busy, bus.pmem_read, bus.pmem_address, a_second);
    end
    bus.pmem_resp = 1'b1;
    bus.if_read   = 1'b0;
    bus.d_read    = 1'b0;
    #1;
    checks++;
    if (bus.d_resp !== ~first_d || bus.if_resp !== first_d) begin
      errors++;
      $display("FAIL cont_second_resp: d_resp=%b if_resp=%b want %b %b", bus.d_resp, bus.if_resp, ~first_d, first_d);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_end: busy=%b want 0", busy);
    end
  endtask

  task automatic test_withdrawal();
    @(negedge clk);
    bus.d_read    = 1'b1;
    bus.d_address = 16'h3000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.d_read    = 1'b0;
        bus.d_address = 16'hFFFF;
      end
      if (c == 3) bus.pmem_resp = 1'b1;
      #1;
      checks++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h3000) begin
        errors++;
        $display("FAIL withdraw_addr c%0d: rd=%b addr=%h want 1 3000", c, bus.pmem_read, bus.pmem_address);
      end
      checks++;
      if (bus.d_resp !== (c == 3)) begin
        errors++;
        $display("FAIL withdraw_resp c%0d: d_resp=%b want %b", c, bus.d_resp, (c == 3));
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_end: busy=%b rd=%b want 0 0", busy, bus.pmem_read);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.if_read    = 1'b1;
    bus.if_address = 16'h0050;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || bus.pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: busy=%b rd=%b want 1 1", busy, bus.pmem_read);
    end
    @(negedge clk);
    rst         = 1'b1;
    bus.if_read = 1'b0;
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0 || busy !== 1'b0 || bus.pmem_address !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_async: rd=%b busy=%b addr=%h want 0 0 0000", bus.pmem_read, busy, bus.pmem_address);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = 16'h5555;
    #1;
    checks++;
    if (bus.if_resp !== 1'b0 || bus.if_rdata !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stray: if_resp=%b if_rdata=%h busy=%b want 0 0000 0", bus.if_resp, bus.if_rdata, busy);
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_end: busy=%b rd=%b want 0 0", busy, bus.pmem_read);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fetch();
    test_spurious();
    test_store();
    test_rw_both();
    test_contention();
    test_withdrawal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
